// File: rtl/turn_if.sv
// Bundle between the tic-tac-toe turn controller and its board/button side.
// master drives buttons and the recorder board; slave is the controller.
interface turn_if;
  logic       start;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_confirm;
  logic [1:0] g0, g1, g2, g3, g4, g5, g6, g7, g8;
  logic [1:0] game_state;
  logic       whos_turn;
  logic [1:0] mark;
  logic [3:0] position;
  logic [3:0] cursor;
  logic [1:0] winner;
  logic       invalid;
  logic       timeout;
  logic [2:0] state_dbg;

  modport master (
    output start, btn_up, btn_down, btn_left, btn_right, btn_confirm,
    output g0, g1, g2, g3, g4, g5, g6, g7, g8,
    input  game_state, whos_turn, mark, position, cursor, winner,
    input  invalid, timeout, state_dbg
  );

  modport slave (
    input  start, btn_up, btn_down, btn_left, btn_right, btn_confirm,
    input  g0, g1, g2, g3, g4, g5, g6, g7, g8,
    output game_state, whos_turn, mark, position, cursor, winner,
    output invalid, timeout, state_dbg
  );
endinterface

// File: rtl/turn_controller.sv
// Cursor/turn referee for three-mark tic-tac-toe: moves the cursor, validates
// confirms against the recorder board, pulses one mark per move, checks wins.
module turn_controller #(
  parameter int SETTLE_CYCLES = 1,
  parameter int TURN_TIMEOUT  = 0,
  parameter int TIMER_W       = 16
) (
  input  logic   clk,
  input  logic   rst,
  turn_if.slave  bus
);
  // Inputs are single-cycle pulses with no ready path; every output is registered.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_COMMIT = 3'd2,
    S_SETTLE = 3'd3,
    S_CHECK  = 3'd4,
    S_OVER   = 3'd5
  } state_t;

  localparam int SETTLE_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);

  state_t               state_q;
  logic [1:0]           game_state_q;
  logic                 whos_turn_q;
  logic [1:0]           mark_q;
  logic [3:0]           position_q;
  logic [3:0]           cursor_q;
  logic [1:0]           winner_q;
  logic                 invalid_q;
  logic                 timeout_q;
  logic [TIMER_W-1:0]   timer_q;
  logic [SETTLE_W-1:0]  settle_q;

  logic [17:0] board;
  logic [1:0]  cur_cell;
  logic [1:0]  mover_code;
  logic [8:0]  own;
  logic        mover_wins;
  logic        timeout_hit;
  logic [3:0]  cursor_up_d, cursor_down_d, cursor_left_d, cursor_right_d;

  always_comb begin
    board      = {bus.g8, bus.g7, bus.g6, bus.g5, bus.g4,
                  bus.g3, bus.g2, bus.g1, bus.g0};
    cur_cell   = board[{cursor_q, 1'b0} +: 2];
    mover_code = whos_turn_q ? 2'b10 : 2'b01;
    own        = '0;
    for (int i = 0; i < 9; i++) begin
      own[i] = (board[2*i +: 2] == mover_code);
    end
    // Only the player who just moved is evaluated.
    mover_wins = (&own[2:0]) | (&own[5:3]) | (&own[8:6]) |
                 (own[0] & own[3] & own[6]) | (own[1] & own[4] & own[7]) |
                 (own[2] & own[5] & own[8]) |
                 (own[0] & own[4] & own[8]) | (own[2] & own[4] & own[6]);
    timeout_hit = (TURN_TIMEOUT > 0) &&
                  (timer_q == TIMER_W'(TURN_TIMEOUT - 1));
  end

  // Wrapping moves keep the other coordinate fixed.
  always_comb begin
    cursor_up_d    = (cursor_q < 4'd3)  ? cursor_q + 4'd6 : cursor_q - 4'd3;
    cursor_down_d  = (cursor_q >= 4'd6) ? cursor_q - 4'd6 : cursor_q + 4'd3;
    cursor_left_d  = (cursor_q == 4'd0 || cursor_q == 4'd3 || cursor_q == 4'd6)
                     ? cursor_q + 4'd2 : cursor_q - 4'd1;
    cursor_right_d = (cursor_q == 4'd2 || cursor_q == 4'd5 || cursor_q == 4'd8)
                     ? cursor_q - 4'd2 : cursor_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      game_state_q <= 2'b00;
      whos_turn_q  <= 1'b1;
      mark_q       <= 2'b00;
      position_q   <= 4'd0;
      cursor_q     <= 4'd4;
      winner_q     <= 2'b00;
      invalid_q    <= 1'b0;
      timeout_q    <= 1'b0;
      timer_q      <= '0;
      settle_q     <= '0;
    end else begin
      invalid_q <= 1'b0;
      timeout_q <= 1'b0;
      mark_q    <= 2'b00;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q      <= S_SELECT;
            game_state_q <= 2'b01;
            timer_q      <= '0;
            cursor_q     <= 4'd4;
          end
        end
        S_SELECT: begin
          timer_q <= timer_q + 1'b1;
          if (bus.btn_confirm && cur_cell == 2'b00) begin
            state_q    <= S_COMMIT;
            mark_q     <= mover_code;
            position_q <= cursor_q;
          end else begin
            if (bus.btn_confirm)    invalid_q <= 1'b1;
            else if (bus.btn_up)    cursor_q  <= cursor_up_d;
            else if (bus.btn_down)  cursor_q  <= cursor_down_d;
            else if (bus.btn_left)  cursor_q  <= cursor_left_d;
            else if (bus.btn_right) cursor_q  <= cursor_right_d;
            // Forfeit overrides any cursor move taken in the same cycle.
            if (timeout_hit) begin
              timeout_q   <= 1'b1;
              whos_turn_q <= ~whos_turn_q;
              cursor_q    <= 4'd4;
              timer_q     <= '0;
            end
          end
        end
        S_COMMIT: begin
          settle_q <= '0;
          state_q  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) state_q <= S_CHECK;
          else settle_q <= settle_q + 1'b1;
        end
        S_CHECK: begin
          if (mover_wins) begin
            state_q      <= S_OVER;
            winner_q     <= mover_code;
            game_state_q <= 2'b10;
          end else begin
            state_q     <= S_SELECT;
            whos_turn_q <= ~whos_turn_q;
            cursor_q    <= 4'd4;
            timer_q     <= '0;
          end
        end
        S_OVER: begin
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.game_state = game_state_q;
  assign bus.whos_turn  = whos_turn_q;
  assign bus.mark       = mark_q;
  assign bus.position   = position_q;
  assign bus.cursor     = cursor_q;
  assign bus.winner     = winner_q;
  assign bus.invalid    = invalid_q;
  assign bus.timeout    = timeout_q;
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: one instance without timeout, one with
// an 8-cycle turn timeout; mark pulses are matched against expected queues.
module tb_turn_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  turn_if b1 ();
  turn_if b2 ();

  turn_controller #(.SETTLE_CYCLES(1), .TURN_TIMEOUT(0), .TIMER_W(16)) dut (
    .clk(clk), .rst(rst), .bus(b1)
  );
  turn_controller #(.SETTLE_CYCLES(1), .TURN_TIMEOUT(8), .TIMER_W(16)) dut_to (
    .clk(clk), .rst(rst), .bus(b2)
  );

  localparam logic [2:0] ST_IDLE = 3'd0, ST_SELECT = 3'd1, ST_COMMIT = 3'd2,
                         ST_SETTLE = 3'd3, ST_CHECK = 3'd4, ST_OVER = 3'd5;

  int total = 0;
  int bad   = 0;
  logic [5:0] exp_q[$];
  logic [5:0] exp2_q[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic u, input logic d, input logic l, input logic r, input logic c);
    b1.btn_up = u; b1.btn_down = d; b1.btn_left = l; b1.btn_right = r; b1.btn_confirm = c;
    tick();
    b1.btn_up = 0; b1.btn_down = 0; b1.btn_left = 0; b1.btn_right = 0; b1.btn_confirm = 0;
  endtask

  task automatic start1();
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
  endtask

  // Scoreboard: every nonzero mark must match the next queued {mark, position}.
  always @(negedge clk) begin
    if (rst && b1.mark !== 2'b00) begin
      if (exp_q.size() == 0) check("b1_unexpected_mark", {10'd0, b1.mark, b1.position}, 16'h0);
      else check("b1_mark_pos", {10'd0, b1.mark, b1.position}, {10'd0, exp_q.pop_front()});
    end
    if (rst && b2.mark !== 2'b00) begin
      if (exp2_q.size() == 0) check("b2_unexpected_mark", {10'd0, b2.mark, b2.position}, 16'h0);
      else check("b2_mark_pos", {10'd0, b2.mark, b2.position}, {10'd0, exp2_q.pop_front()});
    end
  end

  initial begin
    {b1.start, b1.btn_up, b1.btn_down, b1.btn_left, b1.btn_right, b1.btn_confirm} = '0;
    {b2.start, b2.btn_up, b2.btn_down, b2.btn_left, b2.btn_right, b2.btn_confirm} = '0;
    {b1.g0, b1.g1, b1.g2, b1.g3, b1.g4, b1.g5, b1.g6, b1.g7, b1.g8} = '0;
    {b2.g0, b2.g1, b2.g2, b2.g3, b2.g4, b2.g5, b2.g6, b2.g7, b2.g8} = '0;

    // Reset values
    tick(); tick();
    check("rst_game_state", 16'(b1.game_state), 16'd0);
    check("rst_whos_turn",  16'(b1.whos_turn),  16'd1);
    check("rst_mark",       16'(b1.mark),       16'd0);
    check("rst_position",   16'(b1.position),   16'd0);
    check("rst_cursor",     16'(b1.cursor),     16'd4);
    check("rst_winner",     16'(b1.winner),     16'd0);
    check("rst_pulses",     16'({b1.invalid, b1.timeout}), 16'd0);
    check("rst_state",      16'(b1.state_dbg),  16'(ST_IDLE));
    rst = 1'b1;
    tick();

    // Buttons in IDLE are ignored
    press(0, 0, 0, 1, 1);
    check("idle_cursor", 16'(b1.cursor),    16'd4);
    check("idle_state",  16'(b1.state_dbg), 16'(ST_IDLE));

    // Test 1: start, right, confirm; an O row elsewhere must not count for X
    start1();
    check("start_game_state", 16'(b1.game_state), 16'd1);
    check("start_state",      16'(b1.state_dbg),  16'(ST_SELECT));
    press(0, 0, 0, 1, 0);
    check("t1_cursor_right", 16'(b1.cursor), 16'd5);
    b1.g6 = 2'b01; b1.g7 = 2'b01; b1.g8 = 2'b01;
    exp_q.push_back({2'b10, 4'd5});
    press(0, 0, 0, 0, 1);
    check("t1_commit_state", 16'(b1.state_dbg), 16'(ST_COMMIT));
    check("t1_commit_mark",  16'(b1.mark),      16'h2);
    tick();
    check("t1_settle_mark",  16'(b1.mark),      16'd0);
    check("t1_settle_pos",   16'(b1.position),  16'd5);
    check("t1_settle_state", 16'(b1.state_dbg), 16'(ST_SETTLE));
    tick();
    check("t1_check_state",  16'(b1.state_dbg), 16'(ST_CHECK));
    tick();
    check("t1_next_state",   16'(b1.state_dbg), 16'(ST_SELECT));
    check("t1_whos_turn",    16'(b1.whos_turn), 16'd0);
    check("t1_cursor_home",  16'(b1.cursor),    16'd4);
    check("t1_winner",       16'(b1.winner),    16'd0);
    b1.g6 = 2'b00; b1.g7 = 2'b00; b1.g8 = 2'b00;

    // Test 2: cursor wrap
    press(1, 0, 0, 0, 0); check("t2_up1",   16'(b1.cursor), 16'd1);
    press(1, 0, 0, 0, 0); check("t2_up2",   16'(b1.cursor), 16'd7);
    press(0, 0, 1, 0, 0); check("t2_left",  16'(b1.cursor), 16'd6);
    press(0, 0, 1, 0, 0); check("t2_lwrap", 16'(b1.cursor), 16'd8);
    press(0, 1, 0, 0, 0); check("t2_dwrap", 16'(b1.cursor), 16'd2);
    press(0, 0, 0, 1, 0); check("t2_rwrap", 16'(b1.cursor), 16'd0);
    press(0, 1, 0, 0, 0); check("t2_down",  16'(b1.cursor), 16'd3);
    press(0, 0, 0, 1, 0); check("t2_right", 16'(b1.cursor), 16'd4);

    // Test 3: confirm on occupied cell 4
    b1.g4 = 2'b10;
    press(0, 0, 0, 0, 1);
    check("t3_invalid",   16'(b1.invalid),   16'd1);
    check("t3_state",     16'(b1.state_dbg), 16'(ST_SELECT));
    check("t3_whos_turn", 16'(b1.whos_turn), 16'd0);
    check("t3_mark",      16'(b1.mark),      16'd0);
    tick();
    check("t3_invalid_off", 16'(b1.invalid), 16'd0);
    b1.g4 = 2'b00;

    // Test 6: reset asserted during SETTLE
    exp_q.push_back({2'b01, 4'd4});
    press(0, 0, 0, 0, 1);
    tick();
    check("t6_settle_state", 16'(b1.state_dbg), 16'(ST_SETTLE));
    rst = 1'b0;
    #1;
    check("t6_rst_mark",       16'(b1.mark),       16'd0);
    check("t6_rst_game_state", 16'(b1.game_state), 16'd0);
    check("t6_rst_cursor",     16'(b1.cursor),     16'd4);
    check("t6_rst_whos_turn",  16'(b1.whos_turn),  16'd1);
    check("t6_rst_state",      16'(b1.state_dbg),  16'(ST_IDLE));
    tick();
    rst = 1'b1;
    tick();
    start1();
    press(1, 0, 0, 1, 0);
    check("t6_up_beats_right", 16'(b1.cursor), 16'd1);
    press(0, 1, 1, 0, 0);
    check("t6_down_beats_left", 16'(b1.cursor), 16'd4);
    press(1, 0, 0, 0, 0);

    // Test 4: X wins on the top row
    press(0, 0, 0, 1, 0);
    check("t4_cursor", 16'(b1.cursor), 16'd2);
    exp_q.push_back({2'b10, 4'd2});
    press(0, 0, 0, 0, 1);
    b1.g0 = 2'b10; b1.g1 = 2'b10; b1.g2 = 2'b10;
    tick(); tick(); tick();
    check("t4_state",      16'(b1.state_dbg),  16'(ST_OVER));
    check("t4_game_state", 16'(b1.game_state), 16'd2);
    check("t4_winner",     16'(b1.winner),     16'd2);
    b1.start = 1'b1;
    press(1, 0, 0, 0, 1);
    b1.start = 1'b0;
    press(0, 1, 1, 1, 0);
    check("t4_over_state",  16'(b1.state_dbg),  16'(ST_OVER));
    check("t4_over_cursor", 16'(b1.cursor),     16'd2);
    check("t4_over_gs",     16'(b1.game_state), 16'd2);
    check("t4_over_winner", 16'(b1.winner),     16'd2);
    check("t4_over_turn",   16'(b1.whos_turn),  16'd1);
    check("t4_over_pulses", 16'({b1.invalid, b1.timeout, b1.mark}), 16'd0);

    // Test 5: timeout instance
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    b2.start = 1'b1; tick(); b2.start = 1'b0;
    b2.btn_right = 1'b1; tick(); b2.btn_right = 1'b0;
    repeat (6) tick();
    check("t5_cursor_before",  16'(b2.cursor),    16'd5);
    check("t5_no_timeout_yet", 16'(b2.timeout),   16'd0);
    tick();
    check("t5_timeout",        16'(b2.timeout),   16'd1);
    check("t5_turn_flip",      16'(b2.whos_turn), 16'd0);
    check("t5_cursor_home",    16'(b2.cursor),    16'd4);
    check("t5_state",          16'(b2.state_dbg), 16'(ST_SELECT));
    tick();
    check("t5_timeout_off",    16'(b2.timeout),   16'd0);
    repeat (6) tick();
    exp2_q.push_back({2'b01, 4'd4});
    b2.btn_confirm = 1'b1; tick(); b2.btn_confirm = 1'b0;
    check("t5_confirm_no_timeout", 16'(b2.timeout),   16'd0);
    check("t5_confirm_state",      16'(b2.state_dbg), 16'(ST_COMMIT));
    check("t5_confirm_turn",       16'(b2.whos_turn), 16'd0);
    tick(); tick();

    check("b1_queue_drained", 16'(exp_q.size()),  16'd0);
    check("b2_queue_drained", 16'(exp2_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/turn_controller.md
Name: turn_controller

Overview:
Front-end move generator and referee for the three-mark tic-tac-toe board. It takes debounced single-cycle button pulses and moves a cursor over the 3x3 grid. It validates the selected cell against the registered board from the marker/recorder and issues exactly one mark/position command per legal move. After each commit it waits for the recorder to update, checks the new board for a win by the player who just moved, then either passes the turn or ends the game.

Parameters:
SETTLE_CYCLES, 1, number of cycles between the mark pulse and the win check (recorder latency); must be >= 1
TURN_TIMEOUT, 0, number of SELECT cycles before the turn is forfeited; 0 disables the timeout
TIMER_W, 16, width of the turn timer

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; begins a game from IDLE
btn_up / btn_down / btn_left / btn_right  in  1 each  single-cycle cursor pulses
btn_confirm  in  1  single-cycle pulse; place mark at cursor
g0..g8  in  2 each  registered board from recorder outputs (01 O, 10 X, 00 empty); cell index = row*3+col
game_state  out  2  00 IDLE, 01 PLAYING, 10 OVER
whos_turn  out  1  1 X, 0 O
mark  out  2  10 X, 01 O, 00 no move
position  out  4  cell index of the last commit
cursor  out  4  current cursor cell, 0-8
winner  out  2  10 X, 01 O, 00 none
invalid  out  1  one-cycle pulse: confirm was pressed on an occupied cell
timeout  out  1  one-cycle pulse: turn forfeited

Behaviour:
- Reset (asynchronous, active-low) applies in any state, including mid-commit.
  - Reset values: state IDLE, game_state=00, whos_turn=1, mark=00, position=0, cursor=4, winner=00, invalid=0, timeout=0, timer=0.
- Internal FSM states: IDLE, SELECT, COMMIT, SETTLE, CHECK, OVER.
- IDLE:
  - All buttons are ignored.
  - start → SELECT on the next edge; game_state=01 from that edge.
- SELECT cursor movement: cursor changes on the edge after a button pulse.
  - Up: row-1 with wrap 0→2. Down: row+1 with wrap 2→0. Left: col-1 with wrap 0→2. Right: col+1 with wrap 2→0.
  - Row never changes on a left/right wrap; column never changes on an up/down wrap.
  - Simultaneous buttons: priority is confirm > up > down > left > right. Exactly one action is taken per cycle.
- SELECT confirm:
  - Cell g[cursor] == 00: go to COMMIT.
  - Cell occupied: invalid=1 for exactly one cycle; stay in SELECT; timer keeps running.
- COMMIT (exactly 1 cycle):
  - mark = (whos_turn ? 10 : 01).
  - position = cursor, registered together with the mark and held afterwards.
  - Then go to SETTLE.
- mark is 00 in every cycle except COMMIT.
- SETTLE: counts SETTLE_CYCLES cycles, then goes to CHECK.
- CHECK (1 cycle): evaluates 8 lines (3 rows, 3 cols, 2 diagonals) for three cells equal to the current player's mark code.
  - Win: go to OVER; winner = player code; game_state=10.
  - No win: toggle whos_turn; cursor=4; timer=0; go to SELECT.
  - Only the mover can win. Opponent lines are not evaluated; the recorder has already removed the oldest opposing mark.
- Draws do not exist; the game runs until a win or reset.
- Timeout (TURN_TIMEOUT > 0):
  - The timer increments each SELECT cycle.
  - When timer == TURN_TIMEOUT-1 and no valid confirm occurs that cycle: timeout=1 for one cycle, whos_turn toggles, cursor=4, timer=0; stay in SELECT.
  - A valid confirm in the same cycle takes precedence and no timeout is raised.
  - An invalid confirm in the same cycle raises both invalid and timeout.
- OVER: terminal. Buttons and start are ignored; outputs are held; only rst leaves OVER.
- start outside IDLE is ignored.
- Each legal confirm produces exactly one mark pulse. Minimum confirm-to-next-SELECT latency is 1 (COMMIT) + SETTLE_CYCLES + 1 (CHECK) cycles.

Test Plan:
1. Reset, then start, then right, then confirm with an empty board:
   - cursor goes 4 → 5.
   - Exactly one cycle with mark=10, position=5.
   - After SETTLE and CHECK: whos_turn=0, cursor=4, winner=00.
2. Cursor wrap:
   - From cursor 4: up, up gives 1 then 7.
   - From cursor 6: left gives 8; down gives 2.
   - No mark pulse at any point.
3. Occupied cell:
   - Drive g4=10 and confirm at cursor 4.
   - Required: invalid=1 for one cycle, mark stays 00, state remains SELECT, whos_turn unchanged.
4. Win:
   - X commits at position 2 while the bench drives g0=g1=g2=10 after commit.
   - Required in CHECK: game_state=10, winner=10.
   - Later start and button pulses change nothing.
5. Timeout with TURN_TIMEOUT=8 and no buttons:
   - timeout=1 in the 8th SELECT cycle; whos_turn flips.
   - Repeat with confirm on an empty cell in the 8th cycle: mark pulse, no timeout.
6. Reset mid-operation:
   - Assert rst during SETTLE.
   - Required immediately: mark=00, game_state=00, cursor=4, whos_turn=1.
   - Simultaneous up+right pulses in SELECT move the cursor up only.
